// File: rtl/if_stage_if.sv
// if_stage_if: bundles the fetch-stage control, instruction-memory and
// IF/ID signals between the pipeline (master) and the fetch stage (slave).
//
// Signal summary (directions seen from the fetch stage):
//   start_i       in   run enable; 0 freezes the PC and inserts bubbles
//   stall_i       in   load-use stall from the hazard unit
//   flush_i       in   branch taken in ID
//   target_i      in   branch target from the ID adder (bits [1:0] ignored)
//   imem_data_i   in   word returned by the combinational instruction memory
//   imem_addr_o   out  instruction-memory address, always equal to pc_o
//   pc_o          out  current fetch PC
//   ifid_pc_o     out  PC of the instruction held in IF/ID
//   ifid_instr_o  out  instruction held in IF/ID
//   ifid_valid_o  out  1 = IF/ID holds a real instruction, 0 = bubble
//   stall_cnt_o   out  saturating count of stall cycles
//   flush_cnt_o   out  saturating count of flush cycles
//
// Qualifier semantics: there is no valid/ready pair here. ifid_valid_o
// qualifies ifid_pc_o/ifid_instr_o on every cycle; the consumer never
// back-pressures IF/ID except through stall_i, which holds all IF/ID fields.
interface if_stage_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             flush_i;
  logic [PC_W-1:0]  target_i;
  logic [31:0]      imem_data_i;
  logic [PC_W-1:0]  imem_addr_o;
  logic [PC_W-1:0]  pc_o;
  logic [PC_W-1:0]  ifid_pc_o;
  logic [31:0]      ifid_instr_o;
  logic             ifid_valid_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, stall_i, flush_i, target_i, imem_data_i,
    input  imem_addr_o, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, stall_i, flush_i, target_i, imem_data_i,
    output imem_addr_o, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Holds the PC, drives the instruction-memory address combinationally and
// registers the fetched word into the IF/ID pipeline register (1-cycle
// latency). Applies run/flush/stall with priority start > flush > stall.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous, active-high reset
//   bus    if_stage_if.slave (control, imem, IF/ID and counter signals)
//
// Build option: define IF_PERF_CNT_EN to implement the saturating
// stall/flush event counters; otherwise both counter outputs are tied to 0
// and no counter flops exist. PC and IF/ID behaviour is identical.
//
// There is no FSM: the only mode is run/frozen, taken directly from start_i.
module if_stage #(
  parameter int          PC_W     = 32,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic    clk_i,
  input  logic    rst_i,
  if_stage_if.slave bus
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;

  assign bus.pc_o         = pc;
  assign bus.imem_addr_o  = pc;
  assign bus.ifid_pc_o    = ifid_pc;
  assign bus.ifid_instr_o = ifid_instr;
  assign bus.ifid_valid_o = ifid_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc         <= '0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else if (!bus.start_i) begin
      // Frozen: PC holds, a bubble enters IF/ID.
      ifid_pc    <= '0;
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else if (bus.flush_i) begin
      // Redirect to the word-aligned target and squash the wrong-path fetch.
      pc         <= {bus.target_i[PC_W-1:2], 2'b00};
      ifid_pc    <= '0;
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
    end else if (!bus.stall_i) begin
      // Sequential fetch; the add wraps naturally at 2^PC_W.
      pc         <= pc + PC_W'(4);
      ifid_pc    <= pc;
      ifid_instr <= bus.imem_data_i;
      ifid_valid <= 1'b1;
    end
    // Stall: PC and every IF/ID field hold.
  end

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;

  // Counts follow the same priority as the PC update: a flush masks a
  // simultaneous stall, and nothing counts while frozen. Both saturate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.start_i) begin
      if (bus.flush_i) begin
        if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (bus.stall_i) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC-V CPU. It holds the program counter, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register.
- Applies the stall and flush decisions made in ID: the hazard-detection unit supplies the stall, and the branch-taken AND supplies the flush.
- Keeps cycle-accurate stall/flush event counters for the simulation bench.

Parameters:
- PC_W, 32, width of PC and address/target buses
- CNT_W, 32, width of stall/flush counters
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  run enable; 0 freezes PC and inserts bubbles
- stall_i  in  1  load-use stall from hazard unit
- flush_i  in  1  branch taken in ID
- target_i  in  PC_W  branch target from ID adder
- imem_data_i  in  32  instruction word from combinational instruction memory
- imem_addr_o  out  PC_W  equals pc_o
- pc_o  out  PC_W  current fetch PC
- ifid_pc_o  out  PC_W  PC of instruction in IF/ID
- ifid_instr_o  out  32  instruction in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real instruction (0 = bubble)
- stall_cnt_o  out  CNT_W  counted stall cycles
- flush_cnt_o  out  CNT_W  counted flush cycles

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous, active-high.
- Reset values: pc_o=0, ifid_pc_o=0, ifid_instr_o=NOP_WORD, ifid_valid_o=0, stall_cnt_o=0, flush_cnt_o=0. Assertion mid-run clears all state immediately, without waiting for a clock edge. The first fetch after deassertion is from address 0.
- imem_addr_o = pc_o, combinational. The fetched word is registered into IF/ID at the next rising edge, so latency is 1 cycle.
- Per rising edge, the first matching case wins:
  1. start_i=0: PC holds; IF/ID <- bubble (instr=NOP_WORD, valid=0, pc=0); counters hold.
  2. flush_i=1: PC <- {target_i[PC_W-1:2],2'b00}; IF/ID <- bubble; flush_cnt +1. A simultaneous stall_i is ignored and stall_cnt is not incremented.
  3. stall_i=1: PC holds; IF/ID holds all fields; stall_cnt +1.
  4. Otherwise: PC <- PC+4, wrapping modulo 2^PC_W; IF/ID <- {pc_o, imem_data_i, valid=1}.
- Target low bits: target_i bits [1:0] are ignored.
- Counters saturate at all-ones and do not wrap.
- Consecutive cycles:
  - Back-to-back flush cycles each redirect and each count.
  - A stall lasting N cycles adds exactly N to stall_cnt.
- No internal FSM beyond the run/frozen condition selected by start_i. The counters and PC are the only sequential state outside IF/ID.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: stall_cnt_o and flush_cnt_o are implemented as described above.
- Undefined: both ports remain present but are tied to 0, and no counter flops are synthesized. PC and IF/ID behaviour is identical in both builds.

Test Plan:
1. Reset then start_i=1, imem returns 32'h0000_0013 at every address, 4 idle cycles -> pc_o steps 0,4,8,12,16; ifid_pc_o lags by one cycle; ifid_valid_o=1 from cycle 1.
2. At pc_o=8, assert stall_i for 2 cycles -> pc_o stays 8 for 2 edges; IF/ID holds pc 4; stall_cnt_o=2; next normal edge gives pc_o=12.
3. At pc_o=12, flush_i=1 with target_i=32'h0000_0043 -> next pc_o=32'h40; ifid_valid_o=0; ifid_instr_o=0; flush_cnt_o=1.
4. flush_i=1 and stall_i=1 in the same cycle, target 32'h20 -> pc_o=32'h20; bubble inserted; flush_cnt +1; stall_cnt unchanged.
5. Force pc_o to 32'hFFFF_FFFC, run one cycle -> pc_o=0. Then assert rst_i mid-cycle -> all outputs reach reset values before the next clock edge.
6. Drop start_i for 3 cycles at pc_o=16 -> pc_o stays 16; ifid_valid_o=0; counters unchanged. With IF_PERF_CNT_EN undefined, rerun scenarios 2 and 3 -> both counters read 0.
